// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory bulk-access initiator.
package dmem_pkg;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        DUMP = 1'b0,
        FILL = 1'b1
    } mode_t;

endpackage

// File: rtl/dmem_streamer.sv
// Bulk-access initiator for the core's data memory: walks an address window
// and either streams every byte out (dump, with sum/XOR checksums) or writes
// a constant byte into every cell (fill).
//
// Stream handshake: a beat transfers on every rising edge where OutValid and
// OutReady are both high. Once OutValid is raised, OutData/OutAddr/OutLast
// stay stable and OutValid stays high until that transfer happens; OutValid
// never depends combinationally on OutReady.
module dmem_streamer
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] Base,
    input  logic [AW:0]   Len,
    input  logic [DW-1:0] FillVal,
    output logic          Busy,
    output logic          Done,
    output logic [DW-1:0] SumOut,
    output logic [DW-1:0] XorOut,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [DW-1:0] OutData,
    output logic [AW-1:0] OutAddr,
    output logic          OutLast,
    output logic [AW-1:0] MemAddrA,
    output logic [AW-1:0] MemAddrB,
    output logic [DW-1:0] MemDataIn,
    output logic          MemWriteEn,
    input  logic [DW-1:0] MemDataOut
);

    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [AW:0]   LEFT_ONE = 1;
    localparam logic [AW:0]   LEFT_ZERO = '0;

    state_t        state_q, state_d;
    mode_t         mode_q;
    logic [DW-1:0] fill_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   left_q;
    logic [DW-1:0] sum_q, xor_q;
    logic          out_valid_q, out_last_q;
    logic [DW-1:0] out_data_q;
    logic [AW-1:0] out_addr_q;
    logic          load, accept;

    // The output register may take a new beat when it is empty or draining.
    assign load   = !out_valid_q || OutReady;
    assign accept = out_valid_q && OutReady;

    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DONE);
    assign SumOut   = sum_q;
    assign XorOut   = xor_q;
    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;
    assign OutAddr  = out_addr_q;
    assign OutLast  = out_last_q;

    // State register; a synchronous reset aborts any walk at the next edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and direct memory port drive (write strobe is purely
    // a function of state so it drops the cycle after reset).
    always_comb begin
        state_d    = state_q;
        MemAddrA   = '0;
        MemAddrB   = '0;
        MemDataIn  = '0;
        MemWriteEn = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = (Len == LEFT_ZERO) ? DONE : RUN;
                end
            end
            RUN: begin
                if (mode_q == FILL) begin
                    // The memory stores its B-port value, so the fill byte
                    // goes out on both MemAddrB and MemDataIn.
                    MemWriteEn = 1'b1;
                    MemAddrA   = addr_q;
                    MemAddrB   = fill_q;
                    MemDataIn  = fill_q;
                    if (left_q == LEFT_ONE) begin
                        state_d = DONE;
                    end
                end else begin
                    MemAddrB = addr_q;
                    if (accept && out_last_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch, address walk, output beat register and checksums.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode_q      <= DUMP;
            fill_q      <= '0;
            addr_q      <= '0;
            left_q      <= '0;
            sum_q       <= '0;
            xor_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        mode_q <= mode_t'(Mode);
                        fill_q <= FillVal;
                        addr_q <= Base;
                        left_q <= Len;
                        sum_q  <= '0;
                        xor_q  <= '0;
                    end
                end
                RUN: begin
                    if (mode_q == FILL) begin
                        addr_q <= addr_q + ADDR_ONE;
                        left_q <= left_q - LEFT_ONE;
                    end else begin
                        if (accept) begin
                            sum_q <= sum_q + out_data_q;
                            xor_q <= xor_q ^ out_data_q;
                        end
                        if (load) begin
                            if (left_q != LEFT_ZERO) begin
                                out_data_q  <= MemDataOut;
                                out_addr_q  <= addr_q;
                                out_valid_q <= 1'b1;
                                out_last_q  <= (left_q == LEFT_ONE);
                                addr_q      <= addr_q + ADDR_ONE;
                                left_q      <= left_q - LEFT_ONE;
                            end else begin
                                out_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_streamer.sv
// Self-checking bench for dmem_streamer: directed scenarios from the test plan
// followed by randomized dump/fill commands against a behavioural memory model.
module tb_dmem_streamer;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic          Mode;
    logic [AW-1:0] Base;
    logic [AW:0]   Len;
    logic [DW-1:0] FillVal;
    logic          Busy, Done;
    logic [DW-1:0] SumOut, XorOut;
    logic          OutValid, OutReady, OutLast;
    logic [DW-1:0] OutData;
    logic [AW-1:0] OutAddr;
    logic [AW-1:0] MemAddrA, MemAddrB;
    logic [DW-1:0] MemDataIn, MemDataOut;
    logic          MemWriteEn;

    dmem_streamer #(.AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Base(Base),
        .Len(Len), .FillVal(FillVal), .Busy(Busy), .Done(Done),
        .SumOut(SumOut), .XorOut(XorOut), .OutValid(OutValid),
        .OutReady(OutReady), .OutData(OutData), .OutAddr(OutAddr),
        .OutLast(OutLast), .MemAddrA(MemAddrA), .MemAddrB(MemAddrB),
        .MemDataIn(MemDataIn), .MemWriteEn(MemWriteEn), .MemDataOut(MemDataOut)
    );

    // ---------------- clock / reset / memory ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];

    assign MemDataOut = mem[MemAddrB];
    always @(posedge Clk) if (MemWriteEn) mem[MemAddrA] <= MemAddrB;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [16:0] exp_q [$];   // {last, addr, data}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    int beats, extra_beats, we_count, done_count;
    int first_valid_cyc, done_cyc, first_we_cyc, last_we_cyc;
    logic [AW-1:0] op_base;
    logic [DW-1:0] op_fill;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic          prev_last;

    always @(negedge Clk) begin
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(OutValid), 32'd1);
                check("stall_data", 32'(OutData), 32'(prev_data));
                check("stall_addr", 32'(OutAddr), 32'(prev_addr));
                check("stall_last", 32'(OutLast), 32'(prev_last));
            end
            if (OutValid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    extra_beats++;
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", 32'(OutData), 32'(e[7:0]));
                    check("beat_addr", 32'(OutAddr), 32'(e[15:8]));
                    check("beat_last", 32'(OutLast), 32'(e[16]));
                    beats++;
                end
            end
            prev_stall = OutValid && !OutReady;
            prev_data  = OutData;
            prev_addr  = OutAddr;
            prev_last  = OutLast;
            if (MemWriteEn) begin
                check("wr_addr", 32'(MemAddrA), 32'(8'(op_base + 8'(we_count))));
                check("wr_port_b", 32'(MemAddrB), 32'(op_fill));
                check("wr_data_in", 32'(MemDataIn), 32'(op_fill));
                if (we_count == 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
                we_count++;
            end
            if (Done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_counters();
        beats = 0; extra_beats = 0; we_count = 0; done_count = 0;
        first_valid_cyc = -1; done_cyc = -1; first_we_cyc = -1; last_we_cyc = -1;
    endtask

    task automatic check_mem_image(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
        check(tag, 32'(diff), 32'd0);
    endtask

    // ---------------- driver ----------------
    // ready_mode: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    // Call aligned at posedge+#1; returns aligned the same way.
    task automatic run_op(input logic mode, input logic [AW-1:0] base, input int len,
                          input logic [DW-1:0] fv, input int ready_mode, input bit busy_start);
        logic [DW-1:0] exp_sum, exp_xor;
        int s, budget, k;
        exp_sum = '0;
        exp_xor = '0;
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = base + 8'(i);
            if (mode == 1'b0) begin
                exp_q.push_back({(i == len - 1), a, ref_mem[a]});
                exp_sum = exp_sum + ref_mem[a];
                exp_xor = exp_xor ^ ref_mem[a];
            end else begin
                ref_mem[a] = fv;
            end
        end
        clear_counters();
        op_base = base;
        op_fill = fv;
        Mode = mode; Base = base; Len = 9'(len); FillVal = fv;
        OutReady = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        s = cyc;
        Start = 1'b0;
        // Scramble command inputs: they must be ignored outside IDLE.
        Mode = 1'($urandom); Base = 8'($urandom); Len = 9'($urandom); FillVal = 8'($urandom);
        check("busy_after_start", 32'(Busy || Done), 32'd1);
        budget = 3 * len + 20;
        for (k = 0; k < budget; k++) begin
            if (done_count > 0) break;
            case (ready_mode)
                0: OutReady = 1'b1;
                1: OutReady = ((k % 3) == 0);
                default: OutReady = 1'($urandom_range(0, 1));
            endcase
            Start = busy_start && (k == 2);
            @(posedge Clk);
            #1;
        end
        Start = 1'b0;
        check("done_seen_in_budget", 32'(done_count > 0), 32'd1);
        @(posedge Clk);
        #1;
        check("done_pulses", 32'(done_count), 32'd1);
        check("idle_after_done", 32'(Busy), 32'd0);
        check("done_low_after", 32'(Done), 32'd0);
        check("sum_out", 32'(SumOut), 32'(exp_sum));
        check("xor_out", 32'(XorOut), 32'(exp_xor));
        check("extra_beats", 32'(extra_beats), 32'd0);
        check("missing_beats", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (len == 0) begin
            check("len0_done_cyc", 32'(done_cyc), 32'(s));
            check("len0_writes", 32'(we_count), 32'd0);
            check("len0_beats", 32'(beats), 32'd0);
        end else if (mode == 1'b0) begin
            check("dump_writes", 32'(we_count), 32'd0);
            check("dump_beats", 32'(beats), 32'(len));
            check("first_valid_cyc", 32'(first_valid_cyc), 32'(s + 1));
            if (ready_mode == 0) check("dump_done_cyc", 32'(done_cyc), 32'(s + len + 1));
        end else begin
            check("fill_we_cycles", 32'(we_count), 32'(len));
            check("fill_first_we", 32'(first_we_cyc), 32'(s));
            check("fill_last_we", 32'(last_we_cyc), 32'(s + len - 1));
            check("fill_done_cyc", 32'(done_cyc), 32'(last_we_cyc + 1));
            check("fill_beats", 32'(beats), 32'd0);
        end
        check_mem_image("mem_image");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_valid"}, 32'(OutValid), 32'd0);
        check({tag, "_last"}, 32'(OutLast), 32'd0);
        check({tag, "_we"}, 32'(MemWriteEn), 32'd0);
        check({tag, "_data"}, 32'(OutData), 32'd0);
        check({tag, "_addr"}, 32'(OutAddr), 32'd0);
        check({tag, "_sum"}, 32'(SumOut), 32'd0);
        check({tag, "_xor"}, 32'(XorOut), 32'd0);
        check({tag, "_mem_a"}, 32'(MemAddrA), 32'd0);
        check({tag, "_mem_b"}, 32'(MemAddrB), 32'd0);
        check({tag, "_mem_din"}, 32'(MemDataIn), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Base = '0; Len = '0;
        FillVal = '0; OutReady = 1'b1;
        clear_counters();
        op_base = '0; op_fill = '0;
        for (int i = 0; i < 256; i++) begin
            logic [DW-1:0] v;
            v = (i == 0) ? 8'h52 : (i == 1) ? 8'h03 : (i == 2) ? 8'hE6 :
                (i == 3) ? 8'h05 : 8'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Dump without backpressure, explicit checksum values.
        run_op(1'b0, 8'h00, 4, 8'h00, 0, 1'b0);
        check("plan_sum_0x40", 32'(SumOut), 32'h40);
        check("plan_xor_0xb2", 32'(XorOut), 32'hB2);

        // Same dump with 1,0,0 backpressure.
        run_op(1'b0, 8'h00, 4, 8'h00, 1, 1'b0);
        check("bp_sum_0x40", 32'(SumOut), 32'h40);
        check("bp_xor_0xb2", 32'(XorOut), 32'hB2);

        // Address wrap past 0xFF.
        run_op(1'b0, 8'hFE, 4, 8'h00, 0, 1'b0);

        // Fill 0x40..0x42 with 0xAA; 0x43 must be untouched.
        run_op(1'b1, 8'h40, 3, 8'hAA, 0, 1'b0);
        check("fill_cell_40", 32'(mem[8'h40]), 32'hAA);
        check("fill_cell_42", 32'(mem[8'h42]), 32'hAA);
        check("fill_cell_43", 32'(mem[8'h43]), 32'(ref_mem[8'h43]));

        // Zero-length command.
        run_op(1'b0, 8'h10, 0, 8'h00, 0, 1'b0);

        // Second Start during a dump is ignored.
        run_op(1'b0, 8'h00, 8, 8'h00, 0, 1'b1);

        // Full 256-byte wrap-around dump with random backpressure.
        run_op(1'b0, 8'h80, 256, 8'h00, 2, 1'b0);

        // Reset during a 16-byte fill, asserted in the fifth write cycle.
        clear_counters();
        op_base = 8'h80;
        op_fill = 8'h3C;
        Mode = 1'b1; Base = 8'h80; Len = 9'd16; FillVal = 8'h3C; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        check("rst_mid_writes", 32'(we_count), 32'd5);
        check_reset_outputs("rst_mid");
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) ref_mem[8'h80 + i] = 8'h3C;
        repeat (4) @(posedge Clk);
        #1;
        check("rst_mid_no_done", 32'(done_count), 32'd0);
        check("rst_mid_we_after", 32'(we_count), 32'd5);
        check_mem_image("rst_mid_mem");

        // Randomized commands.
        for (int n = 0; n < 24; n++) begin
            logic          m;
            int            l;
            m = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 256))
                                            : int'($urandom_range(0, 20));
            run_op(m, 8'($urandom), l, 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
